mem_subsys: RTL and testbench
=============================

// Module: mem_subsys
// PURPOSE
//   Parametrised data-memory subsystem for the 32-bit RISC computer.
//   Sits between cpu data port and storage: word RAM with byte enables and
//   configurable wait states, plus memory-mapped I/O (output port, cycle
//   counter, halt flag). Asserts stall to freeze the cpu while RAM access pends.
// PARAMETERS
//   N            32            data/address width (multiple of 8)
//   DEPTH_WORDS  64            RAM depth in words, power of two >= 4
//   WAIT_STATES  1             extra cycles per RAM access (0 = single-cycle)
//   MMIO_BASE    32'hFFFF_0000 base of MMIO window (addr >= base -> MMIO)
// PORTS
//   clk          in   1     system clock, all state on rising edge
//   reset        in   1     synchronous, active-low (0 = reset)
//   req_valid    in   1     cpu data access this cycle (load or store)
//   memwrite     in   1     1 = store, 0 = load; valid with req_valid
//   byteen       in   N/8   store byte lanes, bit i -> writedata[8i+7:8i]
//   dataadr      in   N     byte address; bits [1:0] ignored
//   writedata    in   N     store data
//   readdata     out  N     load data; valid only when ack=1, else 0
//   ack          out  1     access completes this cycle
//   stall        out  1     req_valid & ~ack; cpu holds pc/regs while high
//   io_out       out  N     last value written to OUT register
//   io_out_valid out  1     one-cycle pulse when OUT is written
//   halted       out  1     sticky; set by write to HALT register
// BEHAVIOUR
//   Reset (reset==0 at edge): FSM->IDLE, wait cnt=0, cycle cnt=0, io_out=0,
//     io_out_valid=0, halted=0. RAM contents not cleared. Outputs are
//     combinational: readdata=0, ack=0, stall=req_valid.
//   Decode: dataadr>=MMIO_BASE -> MMIO; else RAM word
//     idx=dataadr[$clog2(DEPTH_WORDS)+1:2] (upper bits alias/wrap).
//   MMIO (always zero wait; ack=req_valid combinationally in IDLE):
//     +0x0 OUT   R/W: write -> io_out<=writedata (byteen ignored), pulse.
//     +0x4 CYCLE RO : free-running N-bit counter, +1 every cycle, wraps to 0.
//     +0x8 HALT  W  : any write -> halted<=1; reads return {N-1'b0,halted}.
//     Other offsets: read 0, write ignored; ack still given.
//   RAM FSM: states IDLE, WAIT.
//     WAIT_STATES==0: ack=req_valid in IDLE; read combinational; store
//       commits at the edge ending the ack cycle. stall never asserts.
//     WAIT_STATES=W>0: request seen in IDLE at cycle t latches adr/data/
//       byteen/memwrite, ->WAIT, cnt=1. WAIT: cnt++ each cycle; ack=1
//       when cnt==W (cycle t+W); readdata from latched addr; store commits
//       at edge ending t+W; ->IDLE. A new request at t+W+1 starts fresh.
//     Input changes during WAIT ignored (latched values used).
//     req_valid drop during WAIT: abort ->IDLE, no write, no ack.
//   Reset mid-WAIT: abort, pending store discarded.
//   halted==1: all RAM/MMIO writes suppressed (still acked); reads served;
//     CYCLE keeps counting.
//   Same-cycle load+store impossible (single port); only one access/cycle.
// TESTING
//   T1 W=0: store 0xDEADBEEF @0x10 byteen=4'hF, load @0x10 -> readdata
//      0xDEADBEEF same cycle, stall never 1.
//   T2 W=2: load @0x20 at t -> stall=1 at t,t+1; ack=1,stall=0 at t+2.
//   T3 byteen=4'b0010 store 0x0000AB00 over 0x11223344 -> reads 0x1122AB44.
//   T4 write 0x5A to MMIO_BASE+0 -> io_out=0x5A, io_out_valid one cycle;
//      read MMIO_BASE+4 twice 3 cycles apart -> values differ by 3.
//   T5 W=3 store in flight, reset=0 at t+1 -> location unchanged, FSM IDLE,
//      io_out=0, halted=0.
//   T6 write MMIO_BASE+8 -> halted=1; later store @0x0 -> RAM unchanged;
//      DEPTH=64 alias: store @0x100 reads back @0x0 (before halt).

Source files
------------

// File: rtl/mem_subsys.sv
// mem_subsys: data-memory subsystem for the 32-bit RISC computer.
//
// Sits between the cpu data port and storage. Holds a word-addressed RAM
// with per-byte write enables and a configurable number of wait states, and
// a small memory-mapped I/O window (OUT port, free-running CYCLE counter,
// sticky HALT flag). While a RAM access is pending, stall freezes the cpu.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous, active-low (0 = reset)
//   req_valid    cpu issues a data access this cycle
//   memwrite     1 = store, 0 = load (qualified by req_valid)
//   byteen       store byte lanes, bit i selects writedata[8i+7:8i]
//   dataadr      byte address, bits [1:0] ignored
//   writedata    store data
//   readdata     load data while ack=1, otherwise 0
//   ack          access completes this cycle
//   stall        req_valid & ~ack
//   io_out       last value written to the OUT register
//   io_out_valid one-cycle pulse following an OUT write
//   halted       sticky flag set by any write to the HALT register
module mem_subsys #(
  parameter int             N           = 32,
  parameter int             DEPTH_WORDS = 64,
  parameter int             WAIT_STATES = 1,
  parameter logic [N-1:0]   MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  input  logic           memwrite,
  input  logic [N/8-1:0] byteen,
  input  logic [N-1:0]   dataadr,
  input  logic [N-1:0]   writedata,
  output logic [N-1:0]   readdata,
  output logic           ack,
  output logic           stall,
  output logic [N-1:0]   io_out,
  output logic           io_out_valid,
  output logic           halted
);

  localparam int NB = N / 8;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(WAIT_STATES);
  localparam logic [N-3:0]  OFF_OUT   = (N-2)'(0);
  localparam logic [N-3:0]  OFF_CYCLE = (N-2)'(1);
  localparam logic [N-3:0]  OFF_HALT  = (N-2)'(2);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  // Request captured when a RAM access enters the wait phase.
  logic [N-1:0]    adr_reg;
  logic [N-1:0]    wdata_reg;
  logic [NB-1:0]   be_reg;
  logic            we_reg;

  logic [N-1:0]    cycle_reg;
  logic [N-1:0]    io_out_reg;
  logic            io_out_valid_reg;
  logic            halted_reg;

  logic [N-1:0]    mem [DEPTH_WORDS];

  logic            in_wait;
  logic [N-1:0]    cur_adr;
  logic [N-1:0]    cur_wdata;
  logic [NB-1:0]   cur_be;
  logic            cur_we;
  logic            is_mmio;
  logic [N-3:0]    word_off;
  logic [AW-1:0]   ram_idx;
  logic            ack_c;
  logic            latch_en;
  logic            wr_ok;
  logic            ram_we;
  logic            out_we;
  logic            halt_set;
  logic [N-1:0]    ram_word;
  logic [N-1:0]    merged_word;
  logic [N-1:0]    rdata;

  // While waiting, the access is defined entirely by the captured request;
  // live inputs only matter in IDLE.
  assign in_wait   = (state_reg == ST_WAIT);
  assign cur_adr   = in_wait ? adr_reg   : dataadr;
  assign cur_wdata = in_wait ? wdata_reg : writedata;
  assign cur_be    = in_wait ? be_reg    : byteen;
  assign cur_we    = in_wait ? we_reg    : memwrite;

  assign is_mmio   = (cur_adr >= MMIO_BASE);
  assign word_off  = cur_adr[N-1:2] - MMIO_BASE[N-1:2];
  // Upper address bits above the RAM index simply alias.
  assign ram_idx   = cur_adr[AW+1:2];
  assign ram_word  = mem[ram_idx];

  // Next state / counter / handshake.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ack_c      = 1'b0;
    latch_en   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_mmio || (WAIT_STATES == 0)) begin
            ack_c = 1'b1;
          end else begin
            latch_en   = 1'b1;
            state_next = ST_WAIT;
            cnt_next   = CW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (!req_valid) begin
          // cpu withdrew the request: abandon it without writing.
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          ack_c      = 1'b1;
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Nothing completes while reset is held, so a pending store is dropped.
  assign ack   = reset & ack_c;
  assign stall = req_valid & ~ack;

  assign wr_ok    = ack & cur_we & ~halted_reg;
  assign ram_we   = wr_ok & ~is_mmio;
  assign out_we   = wr_ok & is_mmio & (word_off == OFF_OUT);
  assign halt_set = ack & cur_we & is_mmio & (word_off == OFF_HALT);

  // Byte-lane merge of the store data into the current word.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = cur_be[gi] ? cur_wdata[8*gi +: 8]
                                                 : ram_word[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    rdata = '0;
    if (is_mmio) begin
      case (word_off)
        OFF_OUT:   rdata = io_out_reg;
        OFF_CYCLE: rdata = cycle_reg;
        OFF_HALT:  rdata = {{(N-1){1'b0}}, halted_reg};
        default:   rdata = '0;
      endcase
    end else begin
      rdata = ram_word;
    end
  end

  assign readdata     = ack ? rdata : '0;
  assign io_out       = io_out_reg;
  assign io_out_valid = io_out_valid_reg;
  assign halted       = halted_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      cycle_reg        <= '0;
      io_out_reg       <= '0;
      io_out_valid_reg <= 1'b0;
      halted_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      cycle_reg        <= cycle_reg + {{(N-1){1'b0}}, 1'b1};
      io_out_valid_reg <= out_we;
      if (out_we) begin
        io_out_reg <= cur_wdata;
      end
      if (halt_set) begin
        halted_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      adr_reg   <= dataadr;
      wdata_reg <= writedata;
      be_reg    <= byteen;
      we_reg    <= memwrite;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_mem_subsys.sv
// tb_mem_subsys: drives three mem_subsys instances (0, 2 and 3 wait states)
// with directed and random accesses and compares them against a
// transaction-level model of memory words, OUT, HALT and access latency.
module tb_mem_subsys;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n        [3];
  logic        req_valid    [3];
  logic        memwrite     [3];
  logic [3:0]  byteen       [3];
  logic [31:0] dataadr      [3];
  logic [31:0] writedata    [3];
  logic [31:0] readdata     [3];
  logic        ack          [3];
  logic        stall        [3];
  logic [31:0] io_out       [3];
  logic        io_out_valid [3];
  logic        halted       [3];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] mem_m   [3][64];
  bit          known_m [3][64];
  logic [31:0] io_m    [3];
  bit          halt_m  [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int W = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);
      mem_subsys #(
        .N(32), .DEPTH_WORDS(64), .WAIT_STATES(W), .MMIO_BASE(BASE)
      ) u_dut (
        .clk(clk), .reset(rst_n[gi]), .req_valid(req_valid[gi]),
        .memwrite(memwrite[gi]), .byteen(byteen[gi]), .dataadr(dataadr[gi]),
        .writedata(writedata[gi]), .readdata(readdata[gi]), .ack(ack[gi]),
        .stall(stall[gi]), .io_out(io_out[gi]),
        .io_out_valid(io_out_valid[gi]), .halted(halted[gi])
      );
    end
  endgenerate

  function automatic int ws(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One complete access on instance k: hold the request until ack (bounded),
  // check stall/latency/data, then fold the effect into the model.
  task automatic access(input int k, input bit we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
    bit          mm, got, have_exp, exp_valid;
    int          lat, idx;
    logic [31:0] woff, exp_rd;
    mm       = (a >= BASE);
    woff     = (a >> 2) - (BASE >> 2);
    idx      = int'(a[7:2]);
    have_exp = 1'b0;
    exp_rd   = '0;
    if (mm) begin
      if (woff == 0) begin have_exp = 1'b1; exp_rd = io_m[k]; end
      else if (woff == 2) begin have_exp = 1'b1; exp_rd = {31'd0, halt_m[k]}; end
      else if (woff != 1) begin have_exp = 1'b1; exp_rd = '0; end
    end else if (known_m[k][idx]) begin
      have_exp = 1'b1;
      exp_rd   = mem_m[k][idx];
    end
    exp_valid = we && mm && (woff == 0) && !halt_m[k];

    @(negedge clk);
    req_valid[k] = 1'b1; memwrite[k] = we; byteen[k] = be;
    dataadr[k]   = a;    writedata[k] = wd;
    got = 1'b0; lat = 0; rd = '0;
    for (int c = 0; c < 12; c++) begin
      #2;
      if (ack[k]) begin
        got = 1'b1;
        rd  = readdata[k];
        check("stall_on_ack", stall[k], 0);
        break;
      end
      check("stall_pending", stall[k], 1);
      check("rdata_not_ack", readdata[k], 0);
      lat++;
      @(negedge clk);
    end
    check("ack_seen", got, 1);
    if (got) check("latency", lat, mm ? 0 : ws(k));
    if (got && !we && have_exp) check("load_data", rd, exp_rd);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    memwrite[k]  = 1'b0;
    if (got && we) begin
      if (!halt_m[k]) begin
        if (!mm) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mem_m[k][idx][8*b +: 8] = wd[8*b +: 8];
          if (be == 4'hF) known_m[k][idx] = 1'b1;
        end else if (woff == 0) begin
          io_m[k] = wd;
        end
      end
      if (mm && woff == 2) halt_m[k] = 1'b1;
    end
    check("io_out", io_out[k], io_m[k]);
    check("io_out_valid", io_out_valid[k], got ? exp_valid : 1'b0);
    check("halted", halted[k], halt_m[k]);
  endtask

  task automatic rand_phase(input int k, input int nops);
    logic [31:0] rd, a, wd;
    logic [3:0]  be;
    int          r;
    bit          we;
    for (int i = 0; i < 64; i++) begin
      access(k, 1'b1, 4'hF, i * 4, $urandom, rd);
    end
    for (int i = 0; i < nops; i++) begin
      r  = $urandom_range(0, 9);
      wd = $urandom;
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      case (r)
        0: a = BASE;                                        // OUT
        1: a = BASE + 32'($urandom_range(3, 63) * 4);       // unmapped MMIO
        2: a = BASE - 4 + 32'($urandom_range(0, 3));        // top RAM word
        default: a = $urandom & 32'h0000_FFFF;              // aliased RAM
      endcase
      access(k, we, be, a, wd, rd);
    end
  endtask

  initial begin : main
    logic [31:0] rd, v1, v2;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b1; memwrite[k] = 1'b0;
      byteen[k] = 4'h0; dataadr[k] = '0; writedata[k] = '0;
      io_m[k] = '0; halt_m[k] = 1'b0;
      for (int i = 0; i < 64; i++) begin known_m[k][i] = 1'b0; mem_m[k][i] = '0; end
    end
    repeat (2) @(negedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      check("rst_ack", ack[k], 0);
      check("rst_stall", stall[k], 1);
      check("rst_rdata", readdata[k], 0);
      check("rst_io_out", io_out[k], 0);
      check("rst_io_valid", io_out_valid[k], 0);
      check("rst_halted", halted[k], 0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin rst_n[k] = 1'b1; req_valid[k] = 1'b0; end
    #2;
    check("idle_stall", stall[2], 0);
    check("idle_ack", ack[2], 0);

    // Zero wait states: same-cycle store then load.
    access(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, rd);
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, rd);
    check("t1_load", rd, 32'hDEAD_BEEF);

    // Byte-lane store.
    access(0, 1'b1, 4'hF, 32'h14, 32'h1122_3344, rd);
    access(0, 1'b1, 4'b0010, 32'h14, 32'h0000_AB00, rd);
    access(0, 1'b0, 4'hF, 32'h14, 32'h0, rd);
    check("t3_lane", rd, 32'h1122_AB44);

    // OUT pulse and CYCLE spacing.
    access(0, 1'b1, 4'h0, BASE, 32'h5A, rd);
    check("t4_io_out", io_out[0], 32'h5A);
    @(posedge clk); #1;
    check("t4_pulse_end", io_out_valid[0], 0);
    @(negedge clk);
    req_valid[0] = 1'b1; memwrite[0] = 1'b0; dataadr[0] = BASE + 4;
    #2;
    check("t4_cyc_ack1", ack[0], 1);
    v1 = readdata[0];
    repeat (3) @(negedge clk);
    #2;
    check("t4_cyc_ack2", ack[0], 1);
    v2 = readdata[0];
    check("t4_cyc_delta", v2 - v1, 32'd3);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;

    // Two wait states: stall for two cycles then ack (checked in access).
    access(1, 1'b1, 4'hF, 32'h20, 32'hA5A5_0F0F, rd);
    access(1, 1'b0, 4'hF, 32'h20, 32'h0, rd);
    check("t2_load", rd, 32'hA5A5_0F0F);

    rand_phase(0, 80);
    rand_phase(1, 80);

    // W=3: abort by dropping req_valid mid-wait leaves RAM untouched.
    access(2, 1'b1, 4'hF, 32'h40, 32'h0BAD_F00D, rd);
    access(2, 1'b1, 4'hF, 32'h44, 32'h4444_4444, rd);
    @(negedge clk);
    req_valid[2] = 1'b1; memwrite[2] = 1'b1; byteen[2] = 4'hF;
    dataadr[2] = 32'h40; writedata[2] = 32'h1234_5678;
    #2;
    check("abort_stall", stall[2], 1);
    @(negedge clk);
    req_valid[2] = 1'b0;
    #2;
    check("abort_ack", ack[2], 0);
    access(2, 1'b0, 4'hF, 32'h40, 32'h0, rd);
    check("abort_keep", rd, 32'h0BAD_F00D);

    // Address change during wait is ignored.
    @(negedge clk);
    req_valid[2] = 1'b1; memwrite[2] = 1'b0; dataadr[2] = 32'h40;
    @(negedge clk);
    dataadr[2] = 32'h44;
    repeat (2) @(negedge clk);
    #2;
    check("latched_ack", ack[2], 1);
    check("latched_rd", readdata[2], 32'h0BAD_F00D);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;

    // Reset mid-store discards the store and clears io_out.
    access(2, 1'b1, 4'hF, BASE, 32'h77, rd);
    @(negedge clk);
    req_valid[2] = 1'b1; memwrite[2] = 1'b1; byteen[2] = 4'hF;
    dataadr[2] = 32'h40; writedata[2] = 32'hCAFE_0000;
    @(negedge clk);
    rst_n[2] = 1'b0;
    #2;
    check("t5_rst_ack", ack[2], 0);
    check("t5_rst_stall", stall[2], 1);
    check("t5_rst_rdata", readdata[2], 0);
    @(negedge clk);
    req_valid[2] = 1'b0; memwrite[2] = 1'b0; rst_n[2] = 1'b1;
    io_m[2] = '0; halt_m[2] = 1'b0;
    #2;
    check("t5_io_out", io_out[2], 0);
    check("t5_halted", halted[2], 0);
    check("t5_idle_stall", stall[2], 0);
    access(2, 1'b0, 4'hF, 32'h40, 32'h0, rd);
    check("t5_unchanged", rd, 32'h0BAD_F00D);

    // Reset clears halted and re-enables writes.
    access(2, 1'b1, 4'hF, BASE + 8, 32'h1, rd);
    @(negedge clk); rst_n[2] = 1'b0;
    @(negedge clk); rst_n[2] = 1'b1;
    io_m[2] = '0; halt_m[2] = 1'b0;
    #2;
    check("halt_rst", halted[2], 0);
    access(2, 1'b1, 4'hF, 32'h48, 32'h5555_AAAA, rd);
    access(2, 1'b0, 4'hF, 32'h48, 32'h0, rd);
    check("post_rst_write", rd, 32'h5555_AAAA);

    // Aliasing, then HALT suppresses all writes.
    access(1, 1'b1, 4'hF, 32'h100, 32'hC0DE_0100, rd);
    access(1, 1'b0, 4'hF, 32'h0, 32'h0, rd);
    check("t6_alias", rd, 32'hC0DE_0100);
    access(1, 1'b1, 4'hF, BASE + 8, 32'h0, rd);
    check("t6_halted", halted[1], 1);
    access(1, 1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF, rd);
    access(1, 1'b0, 4'hF, 32'h0, 32'h0, rd);
    check("t6_suppressed", rd, 32'hC0DE_0100);
    access(1, 1'b1, 4'hF, BASE, 32'h9999, rd);
    access(1, 1'b0, 4'hF, BASE + 8, 32'h0, rd);
    check("t6_halt_read", rd, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
